// File: rtl/counter_checker_if.sv
// Signal bundle between a counter response checker and whatever drives it.
// The master side supplies the counter's control inputs and observed Q.
// The slave side (the checker) returns the model value and the error status.
interface counter_checker_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
);

  // Control inputs shared with the counter, plus the counter's Q output
  logic             chk_en;
  logic             enb;
  logic             modo;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] q_obs;

  // Checker status
  logic [WIDTH-1:0] exp_q;
  logic             err_pulse;
  logic             err_flag;
  logic [ERR_W-1:0] err_cnt;
  logic [ERR_W-1:0] wrap_cnt;
  logic [1:0]       state;

  modport master (
    output chk_en,
    output enb,
    output modo,
    output data,
    output q_obs,
    input  exp_q,
    input  err_pulse,
    input  err_flag,
    input  err_cnt,
    input  wrap_cnt,
    input  state
  );

  modport slave (
    input  chk_en,
    input  enb,
    input  modo,
    input  data,
    input  q_obs,
    output exp_q,
    output err_pulse,
    output err_flag,
    output err_cnt,
    output wrap_cnt,
    output state
  );

endinterface

// File: rtl/counter_checker.sv
// Response checker for a WIDTH-bit up-counter with parallel load.
// Runs a cycle-accurate model of the counter from the same control inputs,
// compares the counter's Q against it and keeps saturating error/wrap counts.
module counter_checker #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ERR_W  = 8,
  parameter bit          RESYNC = 1'b1
) (
  input logic            clk,
  input logic            rst,
  counter_checker_if.slave bus
);

  typedef enum logic [1:0] {
    StSync   = 2'd0,
    StCheck  = 2'd1,
    StFail   = 2'd2,
    StUnused = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ModelOnes = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ModelOne  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] CntMax    = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] CntOne    = {{(ERR_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] model_q, model_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_flag_q, err_flag_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic             cmp_active;
  logic             mismatch;
  logic             wrap;
  logic [WIDTH-1:0] model_base;

  // Compare qualification: only in CHECK/FAIL and only when checking is enabled
  always_comb begin
    cmp_active = bus.chk_en && ((state_q == StCheck) || (state_q == StFail));
    mismatch   = cmp_active && (bus.q_obs != model_q);
    // With RESYNC the model continues from what the counter actually showed,
    // so one corrupted value costs exactly one error.
    model_base = (RESYNC && mismatch) ? bus.q_obs : model_q;
  end

  // Counter model: hold, load or increment; flag a counting wrap from all-ones
  always_comb begin
    model_d = model_base;
    wrap    = 1'b0;
    if (bus.enb) begin
      if (bus.modo) begin
        model_d = bus.data;
      end else begin
        model_d = model_base + ModelOne;
        wrap    = (model_base == ModelOnes);
      end
    end
  end

  // FSM next state: SYNC skips one compare, FAIL clears after a clean compare
  always_comb begin
    state_d = state_q;
    case (state_q)
      StSync: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (mismatch) begin
          state_d = StFail;
        end
      end
      StFail: begin
        if (cmp_active && !mismatch) begin
          state_d = StCheck;
        end
      end
      default: begin
        state_d = StSync;
      end
    endcase
  end

  // Error and wrap bookkeeping; both counters saturate at all-ones
  always_comb begin
    err_pulse_d = mismatch;
    err_flag_d  = err_flag_q | mismatch;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
    if (mismatch && (err_cnt_q != CntMax)) begin
      err_cnt_d = err_cnt_q + CntOne;
    end
    if (wrap && (wrap_cnt_q != CntMax)) begin
      wrap_cnt_d = wrap_cnt_q + CntOne;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StSync;
      model_q     <= '0;
      err_pulse_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      model_q     <= model_d;
      err_pulse_q <= err_pulse_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign bus.exp_q     = model_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.wrap_cnt  = wrap_cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: one instance with RESYNC=1 and one with
// RESYNC=0 share the same stimulus; each scenario checks the relevant instance.
module tb_counter_checker;

  logic       clk;
  logic       rst;
  logic       chk_en;
  logic       enb;
  logic       modo;
  logic [3:0] data;
  logic [3:0] q_obs;

  int n_cmp;
  int n_bad;

  counter_checker_if #(.WIDTH(4), .ERR_W(8)) if1 ();
  counter_checker_if #(.WIDTH(4), .ERR_W(8)) if0 ();

  assign if1.chk_en = chk_en;
  assign if1.enb    = enb;
  assign if1.modo   = modo;
  assign if1.data   = data;
  assign if1.q_obs  = q_obs;
  assign if0.chk_en = chk_en;
  assign if0.enb    = enb;
  assign if0.modo   = modo;
  assign if0.data   = data;
  assign if0.q_obs  = q_obs;

  counter_checker #(.WIDTH(4), .ERR_W(8), .RESYNC(1'b1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  counter_checker #(.WIDTH(4), .ERR_W(8), .RESYNC(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    chk_en = 1'b1;
    enb    = 1'b0;
    modo   = 1'b0;
    data   = 4'd0;
    q_obs  = 4'd0;

    // Reset state
    tick();
    check_eq("rst exp_q", int'(if1.exp_q), 0);
    check_eq("rst state", int'(if1.state), 0);
    check_eq("rst err_cnt", int'(if1.err_cnt), 0);
    check_eq("rst wrap_cnt", int'(if1.wrap_cnt), 0);
    check_eq("rst err_flag", int'(if1.err_flag), 0);
    check_eq("rst err_pulse", int'(if1.err_pulse), 0);

    // 1: count up with a correct counter, one wrap
    rst  = 1'b1;
    enb  = 1'b1;
    modo = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      q_obs = 4'((i - 1) % 16);
      tick();
      check_eq("t1 exp_q", int'(if1.exp_q), i % 16);
      check_eq("t1 state", int'(if1.state), 1);
      check_eq("t1 err_pulse", int'(if1.err_pulse), 0);
    end
    check_eq("t1 err_cnt", int'(if1.err_cnt), 0);
    check_eq("t1 wrap_cnt", int'(if1.wrap_cnt), 1);

    // 2: load 6 then count 3
    q_obs = 4'd3;
    modo  = 1'b1;
    data  = 4'd6;
    tick();
    check_eq("t2 load", int'(if1.exp_q), 6);
    modo = 1'b0;
    for (int k = 0; k < 3; k++) begin
      q_obs = 4'(6 + k);
      tick();
      check_eq("t2 exp_q", int'(if1.exp_q), 7 + k);
    end
    check_eq("t2 err_cnt", int'(if1.err_cnt), 0);
    check_eq("t2 wrap_cnt", int'(if1.wrap_cnt), 1);

    // 3: single corrupted value with RESYNC=1
    modo  = 1'b1;
    data  = 4'd3;
    q_obs = 4'd9;
    tick();
    check_eq("t3 exp_q pre", int'(if1.exp_q), 3);
    modo  = 1'b0;
    q_obs = 4'd5;
    tick();
    check_eq("t3 err_pulse", int'(if1.err_pulse), 1);
    check_eq("t3 err_cnt", int'(if1.err_cnt), 1);
    check_eq("t3 err_flag", int'(if1.err_flag), 1);
    check_eq("t3 state fail", int'(if1.state), 2);
    check_eq("t3 resync", int'(if1.exp_q), 6);
    q_obs = 4'd6;
    tick();
    check_eq("t3 pulse clr", int'(if1.err_pulse), 0);
    check_eq("t3 state back", int'(if1.state), 1);
    check_eq("t3 exp_q post", int'(if1.exp_q), 7);
    q_obs = 4'd7;
    tick();
    check_eq("t3 err_cnt post", int'(if1.err_cnt), 1);
    check_eq("t3 exp_q post2", int'(if1.exp_q), 8);

    // 5: reset in mid-count with err_flag set
    for (int k = 8; k <= 10; k++) begin
      q_obs = 4'(k);
      tick();
    end
    check_eq("t5 exp_q mid", int'(if1.exp_q), 11);
    check_eq("t5 flag mid", int'(if1.err_flag), 1);
    rst = 1'b0;
    tick();
    check_eq("t5 exp_q", int'(if1.exp_q), 0);
    check_eq("t5 err_flag", int'(if1.err_flag), 0);
    check_eq("t5 err_cnt", int'(if1.err_cnt), 0);
    check_eq("t5 wrap_cnt", int'(if1.wrap_cnt), 0);
    check_eq("t5 err_pulse", int'(if1.err_pulse), 0);
    check_eq("t5 state", int'(if1.state), 0);
    rst   = 1'b1;
    q_obs = 4'd7;
    tick();
    check_eq("t5 sync no pulse", int'(if1.err_pulse), 0);
    check_eq("t5 sync no cnt", int'(if1.err_cnt), 0);
    check_eq("t5 sync exp_q", int'(if1.exp_q), 1);
    check_eq("t5 sync->check", int'(if1.state), 1);

    // 6: chk_en=0 with wrong q_obs
    chk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      q_obs = 4'd12;
      tick();
      check_eq("t6 exp_q", int'(if1.exp_q), 2 + k);
      check_eq("t6 err_pulse", int'(if1.err_pulse), 0);
    end
    check_eq("t6 err_cnt", int'(if1.err_cnt), 0);
    check_eq("t6 err_flag", int'(if1.err_flag), 0);
    check_eq("t6 state", int'(if1.state), 1);
    chk_en = 1'b1;
    q_obs  = 4'd6;
    tick();
    check_eq("t6 re-en exp_q", int'(if1.exp_q), 7);
    check_eq("t6 re-en pulse", int'(if1.err_pulse), 0);
    q_obs = 4'd7;
    tick();
    check_eq("t6 re-en cnt", int'(if1.err_cnt), 0);

    // chk_en=0 while in FAIL holds the state
    q_obs = 4'd3;
    tick();
    check_eq("t6b fail", int'(if1.state), 2);
    check_eq("t6b exp_q", int'(if1.exp_q), 4);
    chk_en = 1'b0;
    q_obs  = 4'd0;
    tick();
    check_eq("t6b hold state", int'(if1.state), 2);
    check_eq("t6b hold cnt", int'(if1.err_cnt), 1);
    check_eq("t6b no pulse", int'(if1.err_pulse), 0);
    chk_en = 1'b1;
    q_obs  = 4'd5;
    tick();
    check_eq("t6b recover", int'(if1.state), 1);
    check_eq("t6b exp_q2", int'(if1.exp_q), 6);

    // 7: load of 0 from all-ones is not a wrap, counting past all-ones is
    modo  = 1'b1;
    data  = 4'd15;
    q_obs = 4'd6;
    tick();
    data  = 4'd0;
    q_obs = 4'd15;
    tick();
    check_eq("t7 load0 exp_q", int'(if1.exp_q), 0);
    check_eq("t7 load0 wrap", int'(if1.wrap_cnt), 0);
    data  = 4'd15;
    q_obs = 4'd0;
    tick();
    modo  = 1'b0;
    q_obs = 4'd15;
    tick();
    check_eq("t7 count wrap exp_q", int'(if1.exp_q), 0);
    check_eq("t7 count wrap", int'(if1.wrap_cnt), 1);

    // 4: persistent offset with RESYNC=0, error count saturates
    rst = 1'b0;
    tick();
    check_eq("t4 rst state", int'(if0.state), 0);
    check_eq("t4 rst cnt", int'(if0.err_cnt), 0);
    rst   = 1'b1;
    enb   = 1'b1;
    modo  = 1'b0;
    q_obs = 4'd0;
    tick();
    check_eq("t4 sync exp_q", int'(if0.exp_q), 1);
    for (int j = 1; j <= 260; j++) begin
      q_obs = 4'((j + 1) % 16);
      tick();
      if (j == 1) begin
        check_eq("t4 first pulse", int'(if0.err_pulse), 1);
        check_eq("t4 first cnt", int'(if0.err_cnt), 1);
        check_eq("t4 first state", int'(if0.state), 2);
        check_eq("t4 no resync", int'(if0.exp_q), 2);
      end
      if (j == 2) begin
        check_eq("t4 second cnt", int'(if0.err_cnt), 2);
      end
      if (j == 254) begin
        check_eq("t4 cnt 254", int'(if0.err_cnt), 254);
      end
      if (j == 255) begin
        check_eq("t4 cnt 255", int'(if0.err_cnt), 255);
      end
    end
    check_eq("t4 saturated", int'(if0.err_cnt), 255);
    check_eq("t4 pulse", int'(if0.err_pulse), 1);
    check_eq("t4 state", int'(if0.state), 2);
    check_eq("t4 exp_q", int'(if0.exp_q), 5);
    check_eq("t4 wrap_cnt", int'(if0.wrap_cnt), 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
